// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin between ALU (A) and load (B)
// results, feeding one registered write slot that holds while the RF stalls.
module rf_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              rf_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_sel,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              slot_free;
    logic              a_win;
    logic              b_win;
    logic              xfer;
    logic              live;
    logic              conflict;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // last_grant: 0 = A won last, 1 = B won last
    always_comb begin
        slot_free = (state == EMPTY) || !rf_stall;
        a_win     = a_valid && (!b_valid || last_grant);
        b_win     = b_valid && (!a_valid || !last_grant);
        a_ready   = slot_free && a_win;
        b_ready   = slot_free && b_win;
        xfer      = a_ready || b_ready;
        conflict  = a_valid && b_valid;
        sel_addr  = b_ready ? b_addr : a_addr;
        sel_data  = b_ready ? b_data : a_data;
        live      = xfer && (sel_addr != '0);
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (live) state_nxt = FULL;
            end
            FULL: begin
                if (!rf_stall) state_nxt = live ? FULL : EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    assign rf_we = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            wb_sel       <= 1'b0;
            last_grant   <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            if (live) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                wb_sel   <= b_ready;
            end
            if (xfer) last_grant <= b_ready;
            if (xfer && conflict && conflict_cnt != CNT_MAX)
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vectors, accepted writes queued as
// expectations and matched by a monitor as they retire from the slot.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [15:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [15:0] b_data;
    logic        rf_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        wb_sel;
    logic [7:0]  conflict_cnt;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] data;
        logic        sel;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    rf_wb_arbiter #(.DATA_W(16), .ADDR_W(5), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_addr(a_addr),
        .a_data(a_data),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .b_addr(b_addr),
        .b_data(b_data),
        .rf_stall(rf_stall),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .wb_sel(wb_sel),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // A write retires on the edge where the slot is full and the RF is free
    always @(negedge clk) begin
        if (rst_n && rf_we && !rf_stall) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual %h/%h required none",
                         rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("write", 32'({rf_waddr, rf_wdata, wb_sel}), 32'(e));
            end
        end
    end

    task automatic step(input logic av, input logic [4:0] aa,
                        input logic [15:0] ad, input logic bv,
                        input logic [4:0] ba, input logic [15:0] bd,
                        input logic st, input logic ea, input logic eb);
        a_valid  = av;
        a_addr   = aa;
        a_data   = ad;
        b_valid  = bv;
        b_addr   = ba;
        b_data   = bd;
        rf_stall = st;
        @(negedge clk);
        chk("a_ready", 32'(a_ready), 32'(ea));
        chk("b_ready", 32'(b_ready), 32'(eb));
        if (ea && aa != 5'd0) sb.push_back('{aa, ad, 1'b0});
        if (eb && ba != 5'd0) sb.push_back('{ba, bd, 1'b1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        a_valid  = 1'b0;
        a_addr   = '0;
        a_data   = '0;
        b_valid  = 1'b0;
        b_addr   = '0;
        b_data   = '0;
        rf_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_sel", 32'(wb_sel), 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single A write
        step(1'b1, 5'd5, 16'h1234, 1'b0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("t1_we", 32'(rf_we), 32'd1);
        chk("t1_waddr", 32'(rf_waddr), 32'd5);
        chk("t1_wdata", 32'(rf_wdata), 32'h1234);
        chk("t1_sel", 32'(wb_sel), 32'd0);
        idle();
        chk("t1_cnt", 32'(conflict_cnt), 32'd0);

        // four conflicts from reset: A,B,A,B
        do_reset();
        step(1'b1, 5'd1, 16'h0A01, 1'b1, 5'd2, 16'h0B01, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd3, 16'h0A02, 1'b1, 5'd2, 16'h0B01, 1'b0, 1'b0, 1'b1);
        chk("t2_sel_b", 32'(wb_sel), 32'd1);
        step(1'b1, 5'd3, 16'h0A02, 1'b1, 5'd4, 16'h0B02, 1'b0, 1'b1, 1'b0);
        chk("t2_sel_a", 32'(wb_sel), 32'd0);
        step(1'b1, 5'd5, 16'h0A03, 1'b1, 5'd4, 16'h0B02, 1'b0, 1'b0, 1'b1);
        idle();
        chk("t2_cnt", 32'(conflict_cnt), 32'd4);

        // stall hold with both sources waiting
        step(1'b1, 5'd6, 16'h0C06, 1'b0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd7, 16'h0707, 1'b1, 5'd8, 16'h0808, 1'b1, 1'b0, 1'b0);
            chk("t3_hold_we", 32'(rf_we), 32'd1);
            chk("t3_hold_addr", 32'(rf_waddr), 32'd6);
            chk("t3_hold_data", 32'(rf_wdata), 32'h0C06);
        end
        step(1'b1, 5'd7, 16'h0707, 1'b1, 5'd8, 16'h0808, 1'b0, 1'b0, 1'b1);
        chk("t3_next_addr", 32'(rf_waddr), 32'd8);
        step(1'b1, 5'd7, 16'h0707, 1'b0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("t3_cnt", 32'(conflict_cnt), 32'd5);

        // zero-register write from B is consumed
        step(1'b0, 5'd0, 16'h0, 1'b1, 5'd0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        chk("t4_we", 32'(rf_we), 32'd0);
        chk("t4_waddr", 32'(rf_waddr), 32'd7);
        chk("t4_wdata", 32'(rf_wdata), 32'h0707);
        chk("t4_sel", 32'(wb_sel), 32'd0);
        step(1'b1, 5'd9, 16'h0909, 1'b1, 5'd10, 16'h0A0A, 1'b0, 1'b1, 1'b0);
        idle();
        chk("t4_cnt", 32'(conflict_cnt), 32'd6);

        // counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 5'd1, 16'hAAAA, 1'b1, 5'd2, 16'hBBBB, 1'b0,
                 (i % 2 == 0), (i % 2 == 1));
            if (i == 254) chk("t5_cnt_255", 32'(conflict_cnt), 32'd255);
        end
        idle();
        chk("t5_cnt_sat", 32'(conflict_cnt), 32'd255);

        // async reset while a write is held
        step(1'b1, 5'd3, 16'h3333, 1'b0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        a_valid  = 1'b0;
        rf_stall = 1'b1;
        #2;
        chk("t6_pre_we", 32'(rf_we), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t6_async_we", 32'(rf_we), 32'd0);
        chk("t6_async_cnt", 32'(conflict_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 5'd11, 16'h1111, 1'b1, 5'd12, 16'h2222, 1'b0, 1'b1, 1'b0);
        idle();
        idle();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
